// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with load enable; resets asynchronously to RESET_VECTOR.
module pc_reg #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VECTOR;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: BOOT/REQ/HOLD fetch loop with redirect handling.
// Optional misaligned-redirect trap enabled by defining FETCH_SEQ_MISALIGN_TRAP_EN.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  input  logic               core_ready,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  input  logic               stall,
  output logic               misalign_err
);

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t       state_reg, state_next;
  logic [31:0]  pc;
  logic [31:0]  pc_next;
  logic         pc_load;
  logic         capture;
  logic         clear;
  logic         mis_next;
  logic         mis_reg;
  logic         redir_mis;
  logic [31:0]  redir_pc;

  // Without the trap, a misaligned target is silently word-aligned.
  assign redir_mis = TRAP_EN && is_misaligned(redirect_target);
  assign redir_pc  = redir_mis ? TRAP_VECTOR : (redirect_target & ~32'h3);

  pc_reg #(.RESET_VECTOR(RESET_VECTOR)) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_load),
    .d     (pc_next),
    .q     (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_load    = 1'b0;
    pc_next    = pc;
    capture    = 1'b0;
    clear      = 1'b0;
    mis_next   = 1'b0;
    imem_req   = 1'b0;
    case (state_reg)
      ST_BOOT: begin
        state_next = ST_REQ;
        pc_load    = 1'b1;
        pc_next    = RESET_VECTOR;
      end
      ST_REQ: begin
        imem_req = !stall;
        // A redirect discards any same-cycle response and refetches from the target.
        if (redirect_valid) begin
          pc_load  = 1'b1;
          pc_next  = redir_pc;
          mis_next = redir_mis;
        end else if (!stall && imem_ready) begin
          capture    = 1'b1;
          pc_load    = 1'b1;
          pc_next    = pc + PC_INC;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          clear      = 1'b1;
          pc_load    = 1'b1;
          pc_next    = redir_pc;
          mis_next   = redir_mis;
          state_next = ST_REQ;
        end else if (core_ready) begin
          clear      = 1'b1;
          state_next = ST_REQ;
        end
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      mis_reg     <= 1'b0;
    end else begin
      mis_reg <= mis_next;
      if (capture) begin
        instr_valid <= 1'b1;
        instr       <= imem_rdata;
        instr_pc    <= pc;
      end else if (clear) begin
        instr_valid <= 1'b0;
      end
    end
  end

  assign imem_addr    = pc;
  assign misalign_err = mis_reg;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, fetch address after a misaligned redirect (REQ-027 only).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory request valid.
REQ-006 imem_addr  output  32  request address; stable while imem_req=1 and imem_ready=0.
REQ-007 imem_ready  input  1  memory accepts the request and returns imem_rdata in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  instr/instr_pc hold a valid instruction for the core.
REQ-010 instr  output  32  fetched instruction.
REQ-011 instr_pc  output  32  address of instr.
REQ-012 core_ready  input  1  core consumes the instruction when instr_valid=1 and core_ready=1.
REQ-013 redirect_valid  input  1  branch/jump taken; redirect_target replaces the sequential PC.
REQ-014 redirect_target  input  32  redirect address.
REQ-015 stall  input  1  no new request is issued while high.
REQ-016 misalign_err  output  1  one-cycle pulse on a misaligned redirect (REQ-027 only).

Function
REQ-017 FSM states: BOOT, REQ, HOLD; encoding defined in the package.
REQ-018 BOOT: entered on reset; after one cycle, move to REQ with pc=RESET_VECTOR.
REQ-019 REQ: imem_req=!stall, imem_addr=pc; on imem_req&imem_ready, capture instr=imem_rdata, instr_pc=pc, instr_valid=1, pc<=pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), then move to HOLD.
REQ-020 HOLD: imem_req=0; outputs stay stable until core_ready=1; then instr_valid=0 and return to REQ in the next cycle.
REQ-021 Throughput: at most one instruction per 2 cycles; imem_ready tied high gives accept, consume, accept.
REQ-022 redirect_valid is sampled in every state except BOOT; it sets pc<=target (REQ-027 alignment rules) and wins over the pc+4 update in the same cycle.
REQ-023 Redirect in REQ with a same-cycle handshake: drop the response, keep instr_valid=0, stay in REQ, and fetch the target next cycle.
REQ-024 Redirect in HOLD: clear instr_valid (squash) and go to REQ; core_ready that cycle is ignored.
REQ-025 stall=1 never drops a captured instruction; HOLD behaviour does not depend on stall.
REQ-026 redirect_valid during BOOT is ignored.

Configuration
REQ-027 Macro FETCH_SEQ_MISALIGN_TRAP_EN.
- Defined: a redirect_target with [1:0]!=0 pulses misalign_err for one cycle and sets pc<=TRAP_VECTOR.
- Undefined: misalign_err is tied 0 and pc<={target[31:2],2'b00}.

Reset
REQ-028 While RST=0, asynchronously: state=BOOT, pc=RESET_VECTOR, imem_req=0, imem_addr=RESET_VECTOR, instr_valid=0, instr=0, instr_pc=0, misalign_err=0.
REQ-029 RST asserted mid-transaction abandons it; the first request after release is RESET_VECTOR, two cycles after the first rising edge.

Structure
REQ-030 Package fetch_seq_pkg holds the state enum typedef, the instruction width (32), and the PC increment constant (4).
REQ-031 Sub-module pc_reg: 32-bit register with load enable and asynchronous active-low reset to RESET_VECTOR; fetch_sequencer instantiates it once.

Verification
REQ-032 Reset release, imem_ready=1, core_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8 on alternate cycles; instr_pc matches.
REQ-033 imem_ready low for 3 cycles at 0x8 -> imem_addr stays 0x8 and instr_valid=0 throughout; capture on the 4th cycle.
REQ-034 HOLD with core_ready=0 for 5 cycles -> instr/instr_pc stable, imem_req=0; redirect to 0x40 -> instr_valid drops next cycle and the next imem_addr is 0x40.
REQ-035 Redirect to 0x80 in the same cycle as a handshake at 0x10 -> response dropped, no instr_valid, next imem_addr is 0x80.
REQ-036 Redirect to 0x42 -> with the macro: misalign_err pulse and next imem_addr=0x100; without the macro: next imem_addr=0x40 and misalign_err=0.
REQ-037 RST pulsed low while in HOLD and while stall=1 at pc=0xFFFF_FFFC -> all outputs return to reset values immediately; wrap check: after 0xFFFF_FFFC, the next address is 0x0.
